// File: rtl/store_rmw_if.sv
// -----------------------------------------------------------------------------
// store_rmw_if
// Bundles the CPU request/response handshake and the single-port data memory
// bus used by store_rmw_ctrl.
//   slave  : the controller's view (receives requests, drives the memory)
//   master : the environment's view (CPU + memory model)
// Signals:
//   req_valid/req_ready/req_we/req_size/req_addr/req_wdata : CPU request
//   resp_valid/resp_rdata/resp_err                         : CPU response
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata             : memory port
// -----------------------------------------------------------------------------
interface store_rmw_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic        mem_en;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/store_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// store_rmw_ctrl
// Sequences loads, word stores and byte/halfword read-modify-write stores
// onto a single-port, word-wide data memory with a one-cycle read latency.
// Misaligned requests (halfword with addr[0]=1, word with addr[1:0]!=0) are
// answered with resp_err and never touch the memory.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : store_rmw_if.slave (CPU request/response + memory port)
// -----------------------------------------------------------------------------
module store_rmw_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   store_rmw_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WAIT,
      ST_WR,
      ST_DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // Request fields captured at acceptance.
   logic        lat_we;
   logic [1:0]  lat_size;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic        lat_err;
   logic [31:0] merged;

   logic        req_is_word;
   logic        req_mis;
   logic        accept;
   logic [31:0] merge_word;

   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_wdata;

   // Size 2'b11 behaves as a word, so bit 1 alone identifies a word.
   assign req_is_word = bus.req_size[1];
   assign req_mis     = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        (req_is_word && (bus.req_addr[1:0] != 2'b00));
   assign accept      = bus.req_valid && (state == ST_IDLE);

   // NOTE: state and latches use non-blocking assignments so every register
   // samples the pre-edge values of the others, matching real flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we    <= 1'b0;
         lat_size  <= 2'b00;
         lat_addr  <= 32'h0;
         lat_wdata <= 32'h0;
         lat_err   <= 1'b0;
         merged    <= 32'h0;
      end else begin
         if (accept) begin
            lat_we    <= bus.req_we;
            lat_size  <= bus.req_size;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_err   <= req_mis;
         end
         // Old word is only valid in WAIT; capture the merge there so WR
         // does not depend on mem_rdata holding.
         if ((state == ST_WAIT) && lat_we) begin
            merged <= merge_word;
         end
      end
   end

   // Lane merge of the latched store data into the word just read.
   // NOTE: defaults are assigned first in every always_comb so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      merge_word = bus.mem_rdata;
      case (lat_size)
         2'b00:   merge_word[{lat_addr[1:0], 3'b000} +: 8]  = lat_wdata[7:0];
         2'b01:   merge_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
         default: merge_word = lat_wdata;
      endcase
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'h0;
      resp_err   = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_wdata  = 32'h0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) begin
               if (req_mis) begin
                  state_nxt = ST_DONE;
               end else if (bus.req_we && req_is_word) begin
                  state_nxt = ST_WR;
               end else begin
                  state_nxt = ST_RD;
               end
            end
         end
         ST_RD: begin
            mem_en    = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (!lat_we) begin
               resp_valid = 1'b1;
               resp_rdata = bus.mem_rdata;
               state_nxt  = ST_IDLE;
            end else begin
               state_nxt  = ST_WR;
            end
         end
         ST_WR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = lat_size[1] ? lat_wdata : merged;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            resp_valid = 1'b1;
            resp_err   = lat_err;
            state_nxt  = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_rdata = resp_rdata;
   assign bus.resp_err   = resp_err;
   assign bus.mem_en     = mem_en;
   assign bus.mem_we     = mem_we;
   assign bus.mem_addr   = lat_addr[31:2];
   assign bus.mem_wdata  = mem_wdata;

endmodule
